fpq_round_ctrl: RTL and testbench
=================================

Name: fpq_round_ctrl

Overview:
- Round controller and first-press arbiter for the quiz-buzzer (FPQ) design.
- Takes debounced one-cycle key pulses from key_debounce instances: host start, host clear, and four contestant keys.
- Sequences a round through a grab window and an answer window.
- Locks out all but the first valid contestant and flags early presses as fouls.
- Drives the active/channel/count values consumed by the seg_LED/LEDs_n UI logic.

Parameters:
TICK_DIV, 24'd12000000, clk cycles per count tick (1 s at 12 MHz)
GRAB_TIME, 8'd10, ticks allowed for a contestant to press after start
ANS_TIME, 8'd30, ticks allowed for the winner to answer

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
host_start_n  input  1  active-low one-cycle pulse, opens a round
host_clear_n  input  1  active-low one-cycle pulse, returns to IDLE
key_pulse_n  input  4  active-low one-cycle contestant pulses, bit i = contestant i
state  output  3  0 IDLE, 1 ARMED, 2 ANSWER, 3 DONE, 4 FOUL
active  output  2  00 none, 01 valid grab (H), 10 foul (L)
channel  output  4  one-hot contestant latched as winner or fouler, 0 if none
count  output  8  ticks remaining in the current window
buzz  output  1  one-cycle pulse on every grab or foul latch
timeout  output  1  high in DONE when the window expired

Behaviour:
- Reset: one clock, synchronous, active-high; rst high at a clk edge forces state=IDLE, active=00, channel=0, count=0, buzz=0, timeout=0, tick counter=0.
- Reset mid-round: abandons the round immediately, with no buzz.
- All inputs are registered-domain pulses; no synchronizers inside.
- All outputs are registered. An input pulse sampled at edge k appears on the outputs after edge k (1-cycle latency).
- Priority every cycle: rst > clear > contestant press > start > tick expiry.
- Multiple key bits low in the same cycle: lowest index wins (bit 0 highest priority).
- Tick counter:
  - Runs only in ARMED and ANSWER; cleared on every state entry.
  - On reaching TICK_DIV-1 it wraps to 0 and count decrements by 1.
  - count never goes below 0.
- IDLE:
  - Contestant press → FOUL: channel = one-hot of the winning bit, active=10, buzz=1 for one cycle.
  - Otherwise start → ARMED: count=GRAB_TIME, active=00, channel=0, timeout=0.
  - Press and start in the same cycle → FOUL.
- ARMED:
  - Press → ANSWER: channel latched, active=01, count=ANS_TIME, buzz=1 for one cycle.
  - If count is 1 and a tick expires with no press → DONE: count=0, timeout=1, channel=0.
  - Press on the same cycle as the final tick → ANSWER (press wins).
  - start is ignored.
- ANSWER:
  - All key pulses and start are ignored; channel and active hold.
  - Final tick → DONE: count=0, timeout=1; channel and active=01 hold.
- DONE and FOUL:
  - All outputs hold; start and keys are ignored.
  - Only clear or rst leaves.
- clear from any state:
  - Next state IDLE, active=00, channel=0, count=0, timeout=0, buzz=0.
  - clear beats a simultaneous press or start.
- buzz is never high for more than one consecutive cycle.
- GRAB_TIME=0 or ANS_TIME=0 is illegal; the implementation need not handle it.
- channel is always 0 or exactly one-hot.

Test Plan:
All scenarios use TICK_DIV=10, GRAB_TIME=5, ANS_TIME=3, rst pulsed high for 2 cycles at start.
1. rst high → all outputs 0, state=0. Pulse host_start_n → next cycle state=1, count=5. After 10 clk → count=4.
2. From ARMED, pulse key_pulse_n=4'b1011 → state=2, channel=4'b0100, active=01, count=3, buzz high exactly 1 cycle. Later key_pulse_n=4'b1110 → no change. After 30 clk → state=3, count=0, timeout=1, channel=4'b0100.
3. In IDLE, pulse key_pulse_n=4'b0111 → state=4, active=10, channel=4'b1000, buzz 1 cycle. host_start_n pulse → still state=4. host_clear_n pulse → state=0, all outputs 0.
4. ARMED, key_pulse_n=4'b0101 in one cycle → channel=4'b0010. Separately, press aligned with the final grab tick → state=2 (not 3).
5. ARMED with no press for 50 clk → state=3, timeout=1, channel=0, active=00.
6. During ANSWER: host_clear_n together with a key → state=0. rst asserted mid-ARMED → state=0 next cycle, buzz=0.

Source files
------------

// File: rtl/fpq_round_ctrl.sv
// Round controller and first-press arbiter for the quiz buzzer.
// Sequences a round through a grab window and an answer window, latches
// the first contestant key (lowest index on a tie) and flags presses made
// before the round is opened as fouls. All outputs are registered.

// Single-key slice of the tie-break chain: a key wins only if it is pressed
// and no lower-index key is pressed in the same cycle.
module fpq_key_lane (
    input  logic pressed,
    input  logic blocked_in,
    output logic win,
    output logic blocked_out
);
    assign win         = pressed & ~blocked_in;
    assign blocked_out = blocked_in | pressed;
endmodule

module fpq_round_ctrl #(
    parameter logic [23:0] TICK_DIV  = 24'd12000000,
    parameter logic [7:0]  GRAB_TIME = 8'd10,
    parameter logic [7:0]  ANS_TIME  = 8'd30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       host_start_n,
    input  logic       host_clear_n,
    input  logic [3:0] key_pulse_n,
    output logic [2:0] state,
    output logic [1:0] active,
    output logic [3:0] channel,
    output logic [7:0] count,
    output logic       buzz,
    output logic       timeout
);
    localparam int NUM_KEYS = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMED  = 3'd1,
        S_ANSWER = 3'd2,
        S_DONE   = 3'd3,
        S_FOUL   = 3'd4
    } state_t;

    localparam logic [1:0] ACT_NONE  = 2'b00;
    localparam logic [1:0] ACT_GRAB  = 2'b01;
    localparam logic [1:0] ACT_FOUL  = 2'b10;

    // Decoded, active-high view of one cycle's host and contestant inputs.
    typedef struct packed {
        logic                clear;
        logic                start;
        logic                press;
        logic [NUM_KEYS-1:0] win;
    } req_t;

    state_t              state_q;
    logic [23:0]         tick_cnt;
    logic                tick_exp;
    logic [NUM_KEYS-1:0] pressed;
    logic [NUM_KEYS-1:0] win_oh;
    logic [NUM_KEYS:0]   blocked;
    req_t                req;

    assign pressed    = ~key_pulse_n;
    assign blocked[0] = 1'b0;

    // Ripple tie-break: bit 0 has highest priority, so the result is one-hot
    // or zero by construction.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_lane
            fpq_key_lane u_lane (
                .pressed     (pressed[gi]),
                .blocked_in  (blocked[gi]),
                .win         (win_oh[gi]),
                .blocked_out (blocked[gi+1])
            );
        end
    endgenerate

    assign req.clear = ~host_clear_n;
    assign req.start = ~host_start_n;
    assign req.press = blocked[NUM_KEYS];
    assign req.win   = win_oh;

    // The divider only advances inside the two timed windows; in other states
    // it sits at zero because every state entry clears it.
    assign tick_exp = ((state_q == S_ARMED) || (state_q == S_ANSWER)) &&
                      (tick_cnt == TICK_DIV - 24'd1);

    assign state = state_q;

    // Round FSM with registered outputs; priority is clear, press, start, tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            active   <= ACT_NONE;
            channel  <= '0;
            count    <= '0;
            buzz     <= 1'b0;
            timeout  <= 1'b0;
            tick_cnt <= '0;
        end else begin
            buzz <= 1'b0;
            if (req.clear) begin
                state_q  <= S_IDLE;
                active   <= ACT_NONE;
                channel  <= '0;
                count    <= '0;
                timeout  <= 1'b0;
                tick_cnt <= '0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (req.press) begin
                            // Pressing before the round opens is a foul, even
                            // when start arrives in the same cycle.
                            state_q  <= S_FOUL;
                            active   <= ACT_FOUL;
                            channel  <= req.win;
                            buzz     <= 1'b1;
                            tick_cnt <= '0;
                        end else if (req.start) begin
                            state_q  <= S_ARMED;
                            active   <= ACT_NONE;
                            channel  <= '0;
                            count    <= GRAB_TIME;
                            timeout  <= 1'b0;
                            tick_cnt <= '0;
                        end
                    end
                    S_ARMED: begin
                        if (req.press) begin
                            // A press on the final tick still wins the grab.
                            state_q  <= S_ANSWER;
                            active   <= ACT_GRAB;
                            channel  <= req.win;
                            count    <= ANS_TIME;
                            buzz     <= 1'b1;
                            tick_cnt <= '0;
                        end else if (tick_exp) begin
                            tick_cnt <= '0;
                            if (count <= 8'd1) begin
                                state_q <= S_DONE;
                                count   <= '0;
                                timeout <= 1'b1;
                                channel <= '0;
                            end else begin
                                count <= count - 8'd1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 24'd1;
                        end
                    end
                    S_ANSWER: begin
                        // Keys and start are ignored; winner stays latched.
                        if (tick_exp) begin
                            tick_cnt <= '0;
                            if (count <= 8'd1) begin
                                state_q <= S_DONE;
                                count   <= '0;
                                timeout <= 1'b1;
                            end else begin
                                count <= count - 8'd1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 24'd1;
                        end
                    end
                    S_DONE, S_FOUL: begin
                        // Terminal until clear or rst.
                    end
                    default: begin
                        state_q  <= S_IDLE;
                        active   <= ACT_NONE;
                        channel  <= '0;
                        count    <= '0;
                        timeout  <= 1'b0;
                        tick_cnt <= '0;
                    end
                endcase
            end
        end
    end

    // Structural invariants of the arbiter outputs.
    a_buzz_single: assert property (@(posedge clk) disable iff (rst) buzz |=> !buzz);
    a_chan_onehot: assert property (@(posedge clk) $onehot0(channel));
    a_win_onehot:  assert property (@(posedge clk) $onehot0(win_oh));

endmodule

// File: tb/tb_fpq_round_ctrl.sv
// Bench for fpq_round_ctrl: directed vector table for the round scenarios,
// then randomized traffic compared every cycle against a window-time model.
module tb_fpq_round_ctrl;
    localparam logic [23:0] TD = 24'd10;
    localparam logic [7:0]  GT = 8'd5;
    localparam logic [7:0]  AT = 8'd3;

    logic       clk = 1'b0;
    logic       rst, host_start_n, host_clear_n;
    logic [3:0] key_pulse_n;
    logic [2:0] state;
    logic [1:0] active;
    logic [3:0] channel;
    logic [7:0] count;
    logic       buzz, timeout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fpq_round_ctrl #(.TICK_DIV(TD), .GRAB_TIME(GT), .ANS_TIME(AT)) dut (
        .clk          (clk),
        .rst          (rst),
        .host_start_n (host_start_n),
        .host_clear_n (host_clear_n),
        .key_pulse_n  (key_pulse_n),
        .state        (state),
        .active       (active),
        .channel      (channel),
        .count        (count),
        .buzz         (buzz),
        .timeout      (timeout)
    );

    // Reference model: tracks elapsed clocks in the current window and
    // derives the remaining count arithmetically.
    int         m_state, m_elapsed, m_win;
    logic [1:0] m_active;
    logic [3:0] m_channel;
    int         m_count;
    logic       m_buzz, m_timeout;

    function automatic logic [3:0] first_low(input logic [3:0] k);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (!k[i]) begin
                r[i] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic model_step(input logic r, input logic s_n, input logic c_n, input logic [3:0] k);
        logic press;
        press  = (k != 4'hF);
        m_buzz = 1'b0;
        if (r || !c_n) begin
            m_state = 0; m_active = 2'd0; m_channel = '0; m_count = 0; m_timeout = 1'b0;
        end else if (m_state == 0) begin
            if (press) begin
                m_state = 4; m_active = 2'd2; m_channel = first_low(k); m_buzz = 1'b1;
            end else if (!s_n) begin
                m_state = 1; m_win = int'(GT); m_elapsed = 0; m_count = int'(GT);
                m_active = 2'd0; m_channel = '0; m_timeout = 1'b0;
            end
        end else if (m_state == 1 && press) begin
            m_state = 2; m_active = 2'd1; m_channel = first_low(k);
            m_win = int'(AT); m_elapsed = 0; m_count = int'(AT); m_buzz = 1'b1;
        end else if (m_state == 1 || m_state == 2) begin
            m_elapsed++;
            if (m_elapsed == m_win * int'(TD)) begin
                if (m_state == 1) m_channel = '0;
                m_state = 3; m_count = 0; m_timeout = 1'b1;
            end else begin
                m_count = m_win - m_elapsed / int'(TD);
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic s_n, input logic c_n, input logic [3:0] k);
        rst = r; host_start_n = s_n; host_clear_n = c_n; key_pulse_n = k;
        @(posedge clk);
        model_step(r, s_n, c_n, k);
        #1;
    endtask

    typedef struct {
        logic       r, s, c;
        logic [3:0] k;
        int         idle;
        int         st;
        logic [1:0] act;
        logic [3:0] ch;
        int         cnt;
        logic       bz, to;
    } vec_t;

    vec_t tbl[$];

    initial begin
        rst = 1'b1; host_start_n = 1'b1; host_clear_n = 1'b1; key_pulse_n = 4'hF;

        //            r  s  c  keys   idle  st act   ch     cnt bz to
        tbl.push_back('{1, 1, 1, 4'hF,  0,  0, 2'd0, 4'h0, 0, 0, 0}); // reset
        tbl.push_back('{1, 1, 1, 4'hF,  0,  0, 2'd0, 4'h0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 4'hF,  0,  1, 2'd0, 4'h0, 5, 0, 0}); // start
        tbl.push_back('{0, 1, 1, 4'hF,  9,  1, 2'd0, 4'h0, 4, 0, 0}); // first tick
        tbl.push_back('{0, 1, 1, 4'hB,  0,  2, 2'd1, 4'h4, 3, 1, 0}); // grab key 2
        tbl.push_back('{0, 1, 1, 4'hF,  0,  2, 2'd1, 4'h4, 3, 0, 0}); // buzz drops
        tbl.push_back('{0, 1, 1, 4'hE,  0,  2, 2'd1, 4'h4, 3, 0, 0}); // key ignored
        tbl.push_back('{0, 1, 1, 4'hF, 26,  2, 2'd1, 4'h4, 1, 0, 0}); // one before end
        tbl.push_back('{0, 1, 1, 4'hF,  0,  3, 2'd1, 4'h4, 0, 0, 1}); // answer timeout
        tbl.push_back('{0, 0, 1, 4'hF,  0,  3, 2'd1, 4'h4, 0, 0, 1}); // start ignored
        tbl.push_back('{0, 1, 0, 4'hF,  0,  0, 2'd0, 4'h0, 0, 0, 0}); // clear
        tbl.push_back('{0, 1, 1, 4'h7,  0,  4, 2'd2, 4'h8, 0, 1, 0}); // foul key 3
        tbl.push_back('{0, 0, 1, 4'hF,  0,  4, 2'd2, 4'h8, 0, 0, 0}); // start ignored
        tbl.push_back('{0, 1, 0, 4'hF,  0,  0, 2'd0, 4'h0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 4'hF,  0,  1, 2'd0, 4'h0, 5, 0, 0});
        tbl.push_back('{0, 1, 1, 4'h5,  0,  2, 2'd1, 4'h2, 3, 1, 0}); // tie -> key 1
        tbl.push_back('{0, 1, 0, 4'hF,  0,  0, 2'd0, 4'h0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 4'hF,  0,  1, 2'd0, 4'h0, 5, 0, 0});
        tbl.push_back('{0, 1, 1, 4'hF, 48,  1, 2'd0, 4'h0, 1, 0, 0});
        tbl.push_back('{0, 1, 1, 4'hD,  0,  2, 2'd1, 4'h2, 3, 1, 0}); // press on final tick
        tbl.push_back('{0, 1, 0, 4'hF,  0,  0, 2'd0, 4'h0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 4'hF,  0,  1, 2'd0, 4'h0, 5, 0, 0});
        tbl.push_back('{0, 1, 1, 4'hF, 48,  1, 2'd0, 4'h0, 1, 0, 0});
        tbl.push_back('{0, 1, 1, 4'hF,  0,  3, 2'd0, 4'h0, 0, 0, 1}); // grab timeout
        tbl.push_back('{0, 1, 0, 4'hF,  0,  0, 2'd0, 4'h0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 4'hF,  0,  1, 2'd0, 4'h0, 5, 0, 0});
        tbl.push_back('{0, 1, 1, 4'hE,  0,  2, 2'd1, 4'h1, 3, 1, 0});
        tbl.push_back('{0, 1, 0, 4'h0,  0,  0, 2'd0, 4'h0, 0, 0, 0}); // clear beats keys
        tbl.push_back('{0, 0, 1, 4'hF,  0,  1, 2'd0, 4'h0, 5, 0, 0});
        tbl.push_back('{0, 0, 1, 4'hF,  3,  1, 2'd0, 4'h0, 5, 0, 0}); // start in ARMED
        tbl.push_back('{1, 1, 1, 4'hE,  0,  0, 2'd0, 4'h0, 0, 0, 0}); // rst mid-round
        tbl.push_back('{0, 0, 0, 4'hF,  0,  0, 2'd0, 4'h0, 0, 0, 0}); // clear beats start
        tbl.push_back('{0, 0, 1, 4'hC,  0,  4, 2'd2, 4'h1, 0, 1, 0}); // press+start = foul
        tbl.push_back('{0, 1, 0, 4'hF,  0,  0, 2'd0, 4'h0, 0, 0, 0});

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].s, tbl[i].c, tbl[i].k);
            for (int j = 0; j < tbl[i].idle; j++) step(1'b0, 1'b1, 1'b1, 4'hF);
            chk($sformatf("v%0d state", i),   int'(state),   tbl[i].st);
            chk($sformatf("v%0d active", i),  int'(active),  int'(tbl[i].act));
            chk($sformatf("v%0d channel", i), int'(channel), int'(tbl[i].ch));
            chk($sformatf("v%0d count", i),   int'(count),   tbl[i].cnt);
            chk($sformatf("v%0d buzz", i),    int'(buzz),    int'(tbl[i].bz));
            chk($sformatf("v%0d timeout", i), int'(timeout), int'(tbl[i].to));
        end

        // Randomized traffic against the model.
        step(1'b1, 1'b1, 1'b1, 4'hF);
        for (int n = 0; n < 4000; n++) begin
            logic       r, s, c;
            logic [3:0] k;
            r = ($urandom_range(0, 299) == 0);
            c = !($urandom_range(0, 59) == 0);
            s = !($urandom_range(0, 7) == 0);
            k = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
            step(r, s, c, k);
            chk($sformatf("r%0d state", n),   int'(state),   m_state);
            chk($sformatf("r%0d active", n),  int'(active),  int'(m_active));
            chk($sformatf("r%0d channel", n), int'(channel), int'(m_channel));
            chk($sformatf("r%0d count", n),   int'(count),   m_count);
            chk($sformatf("r%0d buzz", n),    int'(buzz),    int'(m_buzz));
            chk($sformatf("r%0d timeout", n), int'(timeout), int'(m_timeout));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
